// File: rtl/spi_pkg.sv
// SPI slave shared definitions.
// Default frame shape and FSM state type.
package spi_pkg;

  localparam int   NBIT_DEF = 8;
  localparam logic CPOL_DEF = 1'b0;
  localparam logic CPHA_DEF = 1'b0;

  typedef enum logic {
    ST_IDLE,
    ST_XFER
  } state_t;

endpackage

// File: rtl/spi_if.sv
// SPI pin bundle.
// Master drives select, clock and data; slave returns miso.
interface spi_if;

  logic ss_n;
  logic sclk;
  logic mosi;
  logic miso;

  modport master (
    output ss_n, sclk, mosi,
    input  miso
  );

  modport slave (
    input  ss_n, sclk, mosi,
    output miso
  );

endinterface

// File: rtl/sync_edge.sv
// Two-flop synchronizer with edge pulses.
// Edges come from the synchronized level and one extra history flop.
module sync_edge #(
  parameter logic INIT = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  // Sync chain plus history flop, cleared to the idle level
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1 <= INIT;
      r_s2 <= INIT;
      r_s3 <= INIT;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_q    = r_s2;
  assign o_rise = r_s2 & ~r_s3;
  assign o_fall = ~r_s2 & r_s3;

endmodule

// File: rtl/spi_slave.sv
// SPI slave, oversampled in the clk domain.
// Configurable frame length, clock polarity and phase.
module spi_slave
  import spi_pkg::*;
#(
  parameter int   Nbit = NBIT_DEF,
  parameter logic Cpol = CPOL_DEF,
  parameter logic Cpha = CPHA_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [Nbit-1:0] tx_data,
  output logic            tx_strobe,
  output logic [Nbit-1:0] rx_data,
  output logic            rx_strobe,
  input  logic            ss_n,
  input  logic            sclk,
  input  logic            mosi,
  output logic            miso
);

  localparam int CW = (Nbit > 1) ? $clog2(Nbit) : 1;
  localparam logic [CW-1:0] LAST = CW'(Nbit - 1);

  logic w_ss_q;
  logic w_ss_rise;
  logic w_ss_fall;
  logic w_sclk_q;
  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_edge;
  logic w_lead;
  logic w_trail;
  logic w_sample;
  logic w_shift;
  logic w_mosi;

  logic            r_mosi_s1;
  logic            r_mosi_s2;
  logic [1:0]      r_arm_cnt;
  logic            r_armed;
  state_t          r_state;
  logic [Nbit-1:0] r_tx;
  logic [Nbit-1:0] r_rx;
  logic [CW-1:0]   r_cnt;
  logic            r_done;
  logic            r_miso;

  sync_edge #(.INIT(1'b1)) u_ss (
    .i_clk  (clk),
    .i_rst  (rst_n),
    .i_d    (ss_n),
    .o_q    (w_ss_q),
    .o_rise (w_ss_rise),
    .o_fall (w_ss_fall)
  );

  sync_edge #(.INIT(Cpol)) u_sclk (
    .i_clk  (clk),
    .i_rst  (rst_n),
    .i_d    (sclk),
    .o_q    (w_sclk_q),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  // Plain two-flop synchronizer for mosi, same latency as sclk
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_mosi_s1 <= 1'b0;
      r_mosi_s2 <= 1'b0;
    end else begin
      r_mosi_s1 <= mosi;
      r_mosi_s2 <= r_mosi_s1;
    end
  end

  assign w_mosi   = r_mosi_s2;
  assign w_edge   = w_sclk_rise | w_sclk_fall;
  assign w_lead   = w_edge & (w_sclk_q != Cpol);
  assign w_trail  = w_edge & (w_sclk_q == Cpol);
  assign w_sample = Cpha ? w_trail : w_lead;
  assign w_shift  = Cpha ? w_lead : w_trail;

  // Ignore the ss_n fall that the reset values fabricate; require
  // a real synchronized high before the first select is accepted
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_arm_cnt <= 2'd0;
      r_armed   <= 1'b0;
    end else begin
      if (r_arm_cnt != 2'd3)
        r_arm_cnt <= r_arm_cnt + 2'd1;
      if (r_arm_cnt == 2'd3 && w_ss_q)
        r_armed <= 1'b1;
    end
  end

  // Frame FSM: load, shift, sample, frame completion and abort
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state   <= ST_IDLE;
      r_tx      <= '0;
      r_rx      <= '0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_miso    <= 1'b0;
      rx_data   <= '0;
      tx_strobe <= 1'b0;
      rx_strobe <= 1'b0;
    end else begin
      tx_strobe <= 1'b0;
      rx_strobe <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (w_ss_fall && r_armed) begin
            r_state   <= ST_XFER;
            r_cnt     <= '0;
            tx_strobe <= 1'b1;
            r_miso    <= tx_data[Nbit-1];
            r_tx      <= Cpha ? tx_data : (tx_data << 1);
          end
        end
        ST_XFER: begin
          if (r_done) begin
            r_done    <= 1'b0;
            rx_data   <= r_rx;
            rx_strobe <= 1'b1;
            if (Cpha && !w_ss_rise) begin
              r_tx      <= tx_data;
              tx_strobe <= 1'b1;
            end
          end
          if (w_ss_rise) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            if (w_sample) begin
              r_rx <= {r_rx[Nbit-2:0], w_mosi};
              if (r_cnt == LAST) begin
                r_cnt  <= '0;
                r_done <= 1'b1;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
            if (w_shift) begin
              if (!Cpha && r_cnt == '0) begin
                r_miso    <= tx_data[Nbit-1];
                r_tx      <= tx_data << 1;
                tx_strobe <= 1'b1;
              end else begin
                r_miso <= r_tx[Nbit-1];
                r_tx   <= r_tx << 1;
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign miso = (r_state == ST_XFER) ? r_miso : 1'bz;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: mode 0 and mode 3 instances.
// Master is behavioural; expectations come from the words it chose.
module tb_spi_slave;

  localparam int HALF = 120;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       sel;
  logic       m_ss;
  logic       m_sclk;
  logic       m_mosi;

  logic       tx_s0, rx_s0, tx_s3, rx_s3;
  logic [7:0] rx_d0, rx_d3;
  wire        w_miso0;
  wire        w_miso3;
  logic       w_mmiso;

  int n_chk = 0;
  int n_pass = 0;
  int tx_cnt0 = 0, rx_cnt0 = 0, tx_cnt3 = 0, rx_cnt3 = 0;
  int last_lead_tx = 0;
  logic p_tx0 = 0, p_rx0 = 0, p_tx3 = 0, p_rx3 = 0;

  pullup (w_miso0);
  pullup (w_miso3);

  spi_if spi0 ();
  spi_if spi3 ();

  assign spi0.ss_n = sel ? 1'b1 : m_ss;
  assign spi0.sclk = sel ? 1'b0 : m_sclk;
  assign spi0.mosi = m_mosi;
  assign spi0.miso = w_miso0;
  assign spi3.ss_n = sel ? m_ss : 1'b1;
  assign spi3.sclk = sel ? m_sclk : 1'b1;
  assign spi3.mosi = m_mosi;
  assign spi3.miso = w_miso3;
  assign w_mmiso   = sel ? spi3.miso : spi0.miso;

  always #10 clk = ~clk;

  spi_slave #(.Nbit(8), .Cpol(1'b0), .Cpha(1'b0)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_data   (tx_data),
    .tx_strobe (tx_s0),
    .rx_data   (rx_d0),
    .rx_strobe (rx_s0),
    .ss_n      (spi0.ss_n),
    .sclk      (spi0.sclk),
    .mosi      (spi0.mosi),
    .miso      (w_miso0)
  );

  spi_slave #(.Nbit(8), .Cpol(1'b1), .Cpha(1'b1)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_data   (tx_data),
    .tx_strobe (tx_s3),
    .rx_data   (rx_d3),
    .rx_strobe (rx_s3),
    .ss_n      (spi3.ss_n),
    .sclk      (spi3.sclk),
    .mosi      (spi3.mosi),
    .miso      (w_miso3)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Strobe counters and single-cycle pulse checks
  always @(negedge clk) begin
    if (p_tx0) chk("tx0_one_cycle", {31'b0, tx_s0}, 32'd0);
    if (p_rx0) chk("rx0_one_cycle", {31'b0, rx_s0}, 32'd0);
    if (p_tx3) chk("tx3_one_cycle", {31'b0, tx_s3}, 32'd0);
    if (p_rx3) chk("rx3_one_cycle", {31'b0, rx_s3}, 32'd0);
    p_tx0 = (tx_s0 === 1'b1);
    p_rx0 = (rx_s0 === 1'b1);
    p_tx3 = (tx_s3 === 1'b1);
    p_rx3 = (rx_s3 === 1'b1);
    if (p_tx0) tx_cnt0++;
    if (p_rx0) rx_cnt0++;
    if (p_tx3) tx_cnt3++;
    if (p_rx3) rx_cnt3++;
  end

  task automatic ss_low();
    m_ss = 1'b0;
    #HALF;
  endtask

  task automatic ss_high();
    m_ss = 1'b1;
    #(2 * HALF);
  endtask

  // MSB-first master; mode follows sel (0: Cpol0/Cpha0, 1: Cpol1/Cpha1)
  task automatic xfer(input logic [7:0] mtx, input int nb,
                      output logic [7:0] mrx);
    logic cp;
    cp  = sel;
    mrx = '0;
    for (int i = 0; i < nb; i++) begin
      if (!cp) begin
        m_mosi = mtx[7-i];
        #HALF;
        m_sclk = 1'b1;
        mrx = {mrx[6:0], w_mmiso};
        if (i == nb - 1) last_lead_tx = tx_cnt0;
        #HALF;
        m_sclk = 1'b0;
      end else begin
        m_sclk = 1'b0;
        m_mosi = mtx[7-i];
        #HALF;
        m_sclk = 1'b1;
        mrx = {mrx[6:0], w_mmiso};
        #HALF;
      end
    end
    #HALF;
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: time limit reached, checks %0d/%0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] mrx;
    logic [7:0] words [0:100];
    logic [7:0] mw [0:99];
    int tc, rc;

    sel = 1'b0; m_ss = 1'b1; m_sclk = 1'b0; m_mosi = 1'b0;
    tx_data = 8'h00; rst_n = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    repeat (10) @(negedge clk);

    chk("rst_rx_data0", {24'b0, rx_d0}, 32'h0);
    chk("rst_tx_strobe0", {31'b0, tx_s0}, 32'h0);
    chk("rst_rx_strobe0", {31'b0, rx_s0}, 32'h0);
    chk("rst_miso0_hiz", {31'b0, w_miso0}, 32'h1);
    chk("rst_rx_data3", {24'b0, rx_d3}, 32'h0);
    chk("rst_miso3_hiz", {31'b0, w_miso3}, 32'h1);

    // Mode 0 directed
    tx_data = 8'hA5;
    rc = rx_cnt0;
    ss_low();
    xfer(8'h3C, 8, mrx);
    chk("m0_master_rx", {24'b0, mrx}, 32'hA5);
    chk("m0_rx_data", {24'b0, rx_d0}, 32'h3C);
    chk("m0_rx_pulses", rx_cnt0 - rc, 32'd1);
    ss_high();
    chk("m0_miso_hiz", {31'b0, w_miso0}, 32'h1);

    // Random back-to-back frames in one select
    for (int k = 0; k <= 100; k++) words[k] = 8'($urandom);
    for (int k = 0; k < 100; k++) mw[k] = 8'($urandom);
    tx_data = words[0];
    tc = tx_cnt0;
    rc = rx_cnt0;
    ss_low();
    for (int k = 0; k < 100; k++) begin
      #($urandom_range(0, 19));
      tx_data = words[k+1];
      xfer(mw[k], 8, mrx);
      chk("rnd_master_rx", {24'b0, mrx}, {24'b0, words[k]});
      chk("rnd_slave_rx", {24'b0, rx_d0}, {24'b0, mw[k]});
    end
    chk("rnd_tx_pulses", last_lead_tx - tc, 32'd100);
    chk("rnd_rx_pulses", rx_cnt0 - rc, 32'd100);
    ss_high();

    // Abort after 5 bits
    tx_data = 8'hC3;
    rc = rx_cnt0;
    ss_low();
    xfer(8'h55, 5, mrx);
    ss_high();
    chk("abort_no_rx", rx_cnt0 - rc, 32'd0);
    chk("abort_rx_kept", {24'b0, rx_d0}, {24'b0, mw[99]});
    chk("abort_miso_hiz", {31'b0, w_miso0}, 32'h1);
    tx_data = 8'h3A;
    ss_low();
    xfer(8'hFF, 8, mrx);
    chk("post_abort_rx", {24'b0, rx_d0}, 32'hFF);
    chk("post_abort_mrx", {24'b0, mrx}, 32'h3A);
    chk("post_abort_pulses", rx_cnt0 - rc, 32'd1);
    ss_high();

    // Reset after 4 bits, ss_n left low
    tx_data = 8'h12;
    ss_low();
    xfer(8'hAA, 4, mrx);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_rx_data", {24'b0, rx_d0}, 32'h0);
    chk("midrst_tx_strobe", {31'b0, tx_s0}, 32'h0);
    chk("midrst_rx_strobe", {31'b0, rx_s0}, 32'h0);
    chk("midrst_miso_hiz", {31'b0, w_miso0}, 32'h1);
    rst_n = 1'b0;
    tc = tx_cnt0;
    rc = rx_cnt0;
    repeat (2) begin
      #HALF m_sclk = 1'b1;
      #HALF m_sclk = 1'b0;
    end
    #HALF;
    chk("postrst_no_start", tx_cnt0 - tc, 32'd0);
    chk("postrst_miso_hiz", {31'b0, w_miso0}, 32'h1);
    ss_high();
    tx_data = 8'h81;
    ss_low();
    xfer(8'h7E, 8, mrx);
    chk("postrst_mrx", {24'b0, mrx}, 32'h81);
    chk("postrst_rx", {24'b0, rx_d0}, 32'h7E);
    chk("postrst_pulses", rx_cnt0 - rc, 32'd1);
    ss_high();

    // Mode 3 instance
    m_sclk = 1'b1;
    sel = 1'b1;
    #(2 * HALF);
    tx_data = 8'h5A;
    rc = rx_cnt3;
    ss_low();
    xfer(8'h96, 8, mrx);
    chk("m3_master_rx", {24'b0, mrx}, 32'h5A);
    chk("m3_rx_data", {24'b0, rx_d3}, 32'h96);
    chk("m3_rx_pulses", rx_cnt3 - rc, 32'd1);
    ss_high();
    chk("m3_miso_hiz", {31'b0, w_miso3}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Nbit, default 8: frame length in bits, and the width of tx_data and rx_data.
REQ-002 Cpol, default 0: SCLK idle level.
REQ-003 Cpha, default 0: 0 = sample on leading SCLK edge, shift on trailing edge; 1 = shift on leading edge, sample on trailing edge.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  in  1  system clock; the only clock in the design.
REQ-006 rst_n  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-007 tx_data  in  Nbit  word to transmit; sampled on the clk edge that asserts tx_strobe.
REQ-008 tx_strobe  out  1  one-cycle pulse; tx_data was captured on this edge.
REQ-009 rx_data  out  Nbit  last received word; held stable until the next rx_strobe.
REQ-010 rx_strobe  out  1  one-cycle pulse; rx_data is valid from this cycle on.
REQ-011 ss_n  in  1  active-low slave select, asynchronous to clk.
REQ-012 sclk  in  1  SPI clock, asynchronous to clk.
REQ-013 mosi  in  1  master-to-slave data, asynchronous to clk.
REQ-014 miso  out  1  slave-to-master data; high-impedance while ss_n is synchronized high.
REQ-015 The SPI pins are carried by interface spi_if, which has logic signals ss_n, sclk, mosi and miso; the slave connects to them as individual ports.

Function
REQ-016 ss_n, sclk and mosi each pass through a 2-flop synchronizer before use; ss_n and sclk are edge-detected in the clk domain.
REQ-017 Leading edge = SCLK transition away from Cpol; trailing edge = transition back to Cpol.
REQ-018 Data is MSB first in both directions.
REQ-019 States: IDLE (ss_n high) and XFER (ss_n low).
REQ-020 On a synchronized ss_n falling edge: load tx_data into the tx shift register, pulse tx_strobe, clear the bit counter, enter XFER.
REQ-021 Cpha=0: miso drives the MSB from the load cycle; sample mosi on leading edges; shift the next bit out on trailing edges.
REQ-022 Cpha=1: shift a bit out on each leading edge (the MSB on the first); sample mosi on trailing edges.
REQ-023 After the Nbit-th sample, on the next clk edge: copy the rx shift register to rx_data and pulse rx_strobe for one cycle.
REQ-024 If ss_n stays low after Nbit bits, start a new frame.
REQ-025 For a new frame within one select: reload tx_data with a tx_strobe pulse on the trailing edge of the last bit (Cpha=0), or at frame end (Cpha=1).
REQ-026 ss_n rising before Nbit bits: abort the frame, no rx_strobe, rx_data unchanged, return to IDLE, miso to high-impedance.
REQ-027 SCLK edges seen while in IDLE are ignored.
REQ-028 tx_strobe and rx_strobe are never asserted for more than one cycle.
REQ-029 Timing contract for the master: SCLK half-period >= 4 clk periods.
REQ-030 Timing contract for the master: first SCLK edge >= 4 clk periods after ss_n falls.
REQ-031 Timing contract for the master: ss_n high time between selects >= 4 clk periods.

Reset
REQ-032 While rst_n=1: state IDLE, shift registers 0, counter 0, rx_data 0, tx_strobe 0, rx_strobe 0.
REQ-033 While rst_n=1: miso is high-impedance and synchronizers are cleared to the idle levels (ss_n=1, sclk=Cpol).
REQ-034 Reset asserted mid-frame aborts the frame with no strobes.
REQ-035 After reset is released, the first frame starts only on a new ss_n falling edge.

Structure
REQ-036 spi_if is defined in its own file.
REQ-037 Package spi_pkg holds the default Nbit, Cpol and Cpha constants, plus the state enum typedef.
REQ-038 One sub-module, sync_edge: a 2-flop synchronizer with rise/fall pulse outputs, instantiated for ss_n and sclk, with a plain synchronizer for mosi.

Verification
REQ-039 Reset, then idle -> rx_data=0, both strobes 0, miso high-impedance.
REQ-040 Mode 0, tx_data=hA5 at tx_strobe, master sends h3C -> master receives hA5; rx_strobe pulses once; rx_data=h3C.
REQ-041 100 random back-to-back frames, clk/master phase offset random in 0..19 ns, clk 20 ns -> every frame: slave tx equals master rx and slave rx equals master tx; 100 tx_strobe and 100 rx_strobe pulses.
REQ-042 ss_n raised after 5 bits -> no rx_strobe, rx_data keeps its previous value; the next full frame (hFF) is received correctly.
REQ-043 Reset asserted after 4 bits -> all outputs return to reset values; the following frame h81/h7E is exchanged correctly.
REQ-044 Cpol=1/Cpha=1 instance, tx h5A and master h96 -> master receives h5A; rx_data=h96.
